// File: rtl/seq_div_pkg.sv
// seq_div_pkg -- shared definitions for the iterative divider.
//   Op codes  : DIV_OP, DIVU_OP, REM_OP, REMU_OP (RV32M funct encodings as
//               seen by the divider request port).
//   state_t   : divider FSM state encoding, also driven out on the debug
//               port of seq_divider.
//   negate    : two's complement negate.
//   abs_val   : magnitude of a value whose sign is supplied by the caller.
// The helpers work on a 64-bit container; callers zero-extend narrower
// operands and keep the low bits of the result, which is exact for
// two's complement arithmetic.
package seq_div_pkg;

  localparam logic [4:0] DIV_OP  = 5'd17;
  localparam logic [4:0] DIVU_OP = 5'd18;
  localparam logic [4:0] REM_OP  = 5'd19;
  localparam logic [4:0] REMU_OP = 5'd20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [63:0] negate(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // The sign is passed in because a zero-extended operand no longer has
  // its sign bit at position 63.
  function automatic logic [63:0] abs_val(input logic [63:0] v, input logic is_neg);
    return is_neg ? negate(v) : v;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step -- one radix-2 restoring division iteration (combinational).
//   rem       in  WIDTH  partial remainder (always < dmag)
//   quo       in  WIDTH  quotient register; its MSB is the next dividend bit
//   dmag      in  WIDTH  divisor magnitude
//   rem_next  out WIDTH  remainder after shift and trial subtract
//   quo_next  out WIDTH  quotient shifted left with the new bit in the LSB
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One extra bit: the shifted remainder can reach 2*dmag-1.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dmag};
  // diff MSB set means the trial subtraction went negative: restore.
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- iterative radix-2 divider for DIV, DIVU, REM, REMU.
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  request handshake; req_op, dividend, divisor qualify it
//   flush            abort the in-flight operation (no response produced)
//   resp_valid/ready response handshake; result qualifies it
//   state            debug view of the FSM state (seq_div_pkg::state_t)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low; resp_valid and result are registered and do not change
// until the consumer takes them. One operation is in flight at a time.
// Optional feature macro: SEQ_DIVIDER_RESULT_CACHE_EN keeps the last
// completed quotient/remainder so a matching request returns in one cycle.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           st;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q, quo_q, dmag_q;
  logic             neg_q, neg_r, is_rem_q;

  // Request decode; unknown op codes fall through as DIVU.
  logic             req_signed, req_is_rem, sign_a, sign_b, div_zero, overflow;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign req_signed = (req_op == DIV_OP) || (req_op == REM_OP);
  assign req_is_rem = (req_op == REM_OP) || (req_op == REMU_OP);
  assign sign_a     = req_signed & dividend[WIDTH-1];
  assign sign_b     = req_signed & divisor[WIDTH-1];
  assign div_zero   = (divisor == '0);
  assign overflow   = req_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign abs_a      = WIDTH'(abs_val(64'(dividend), sign_a));
  assign abs_b      = WIDTH'(abs_val(64'(divisor), sign_b));

  logic [WIDTH-1:0] rem_next, quo_next, q_fix, r_fix;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dmag     (dmag_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign q_fix = neg_q ? WIDTH'(negate(64'(quo_q))) : quo_q;
  assign r_fix = neg_r ? WIDTH'(negate(64'(rem_q))) : rem_q;

  assign state = st;

`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
  logic             c_valid, c_signed, s_q, cache_hit;
  logic [WIDTH-1:0] c_a, c_b, c_q, c_r, a_q, b_q;

  assign cache_hit = c_valid && (c_a == dividend) && (c_b == divisor) &&
                     (c_signed == req_signed);

  // Operands are captured at accept so they are available when FIXUP
  // commits the entry; special cases never reach FIXUP and are not cached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      s_q      <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (st == S_IDLE && req_valid) begin
      a_q <= dividend;
      b_q <= divisor;
      s_q <= req_signed;
    end else if (st == S_FIXUP) begin
      c_valid  <= 1'b1;
      c_a      <= a_q;
      c_b      <= b_q;
      c_signed <= s_q;
      c_q      <= q_fix;
      c_r      <= r_fix;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      result     <= '0;
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dmag_q     <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_rem_q   <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          // flush wins over a simultaneous request
          if (req_valid && !flush) begin
            is_rem_q  <= req_is_rem;
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= sign_a;
            rem_q     <= '0;
            quo_q     <= abs_a;
            dmag_q    <= abs_b;
            count     <= CW'(WIDTH - 1);
            req_ready <= 1'b0;
            if (div_zero) begin
              result     <= req_is_rem ? dividend : '1;
              resp_valid <= 1'b1;
              st         <= S_DONE;
            end else if (overflow) begin
              result     <= req_is_rem ? '0 : MIN_NEG;
              resp_valid <= 1'b1;
              st         <= S_DONE;
`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
            end else if (cache_hit) begin
              result     <= req_is_rem ? c_r : c_q;
              resp_valid <= 1'b1;
              st         <= S_DONE;
`endif
            end else begin
              st <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            st        <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - 1'b1;
            if (count == '0) st <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (flush) begin
            st        <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            result     <= is_rem_q ? r_fix : q_fix;
            resp_valid <= 1'b1;
            st         <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            st         <= S_IDLE;
          end
        end
        default: begin
          st         <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- self-checking bench for seq_divider.
// Expected results and latencies are pushed when a request is driven and
// popped when the response arrives. Build with SEQ_DIVIDER_RESULT_CACHE_EN
// defined to check the result cache latencies.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] result;
  logic [1:0]  state;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .state      (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
  logic        m_valid = 1'b0;
  logic        m_signed = 1'b0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
`endif

  function automatic logic op_signed(input logic [4:0] op);
    return (op == 5'd17) || (op == 5'd19);
  endfunction

  function automatic logic is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (op_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference result using the simulator's own division operators.
  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic        sgn, rem;
    sgn = op_signed(op);
    rem = (op == 5'd19) || (op == 5'd20);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rem ? r : q;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (is_special(op, a, b)) return 1;
`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
    if (m_valid && m_a == a && m_b == b && m_signed == op_signed(op)) return 1;
`endif
    return 34;
  endfunction

  task automatic clear_model_cache();
`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
    m_valid = 1'b0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Drives one request; returns just after the accepting clock edge (cycle 0).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit expect_resp);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    if (expect_resp) begin
      exp_q.push_back(exp);
      lat_q.push_back(model_lat(op, a, b));
`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
      if (!is_special(op, a, b)) begin
        m_valid  = 1'b1;
        m_a      = a;
        m_b      = b;
        m_signed = op_signed(op);
      end
`endif
    end
    req_valid = 1'b1;
    req_op    = op;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid, counting cycles from the accept cycle,
  // then completes the response handshake.
  task automatic wait_resp(output logic [31:0] res, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    res = result;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++;
    if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [4:0]  t_op  [10] = '{5'd18, 5'd20, 5'd17, 5'd19, 5'd19, 5'd18, 5'd19, 5'd17, 5'd19, 5'd0};
  logic [31:0] t_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd100};
  logic [31:0] t_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
  logic [31:0] t_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd14};

  task automatic test_table();
    logic [31:0] res, exp;
    int          lat, elat;
    bit          to;
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_exp[i], 1'b1);
      wait_resp(res, lat, to);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_checks++;
      if (to || res !== exp) begin
        n_fail++;
        $display("FAIL table[%0d]_result: got %h want %h timeout=%0d", i, res, exp, to);
      end
      n_checks++;
      if (lat != elat) begin
        n_fail++;
        $display("FAIL table[%0d]_latency: got %0d want %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  ops [6] = '{5'd17, 5'd18, 5'd19, 5'd20, 5'd0, 5'd21};
    logic [4:0]  op;
    logic [31:0] a, b, res, exp;
    int          lat, elat;
    bit          to;
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (i == 0) a = 32'h8000_0000;
      issue(op, a, b, ref_div(op, a, b), 1'b1);
      wait_resp(res, lat, to);
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_checks++;
      if (to || res !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp);
      end
      n_checks++;
      if (lat != elat) begin
        n_fail++;
        $display("FAIL random[%0d]_latency: got %0d want %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int          lat, elat;
    bit          seen;
    issue(5'd18, 32'd1000, 32'd9, 32'd111, 1'b1);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || lat != elat) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want %0d seen=%0d", lat, elat, seen);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (result !== exp || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: result=%h valid=%b ready=%b want %h 1 0", i, result, resp_valid, req_ready, exp);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: state=%0d ready=%b valid=%b want 0 1 0", state, req_ready, resp_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, exp;
    int          lat, elat;
    bit          to, saw;
    issue(5'd18, 32'd12345, 32'd7, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL flush_pre_state: got %0d want 1", state); end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    clear_model_cache();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_calc: ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL flush_no_resp: resp_valid=1 want 0"); end
    // flush together with a request in IDLE: the request is dropped
    req_valid = 1'b1;
    req_op    = 5'd18;
    dividend  = 32'd50;
    divisor   = 32'd5;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: state=%0d ready=%b valid=%b want 0 1 0", state, req_ready, resp_valid);
    end
    issue(5'd18, 32'd9, 32'd3, 32'd3, 1'b1);
    wait_resp(res, lat, to);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    n_checks++;
    if (to || res !== exp) begin n_fail++; $display("FAIL flush_after_result: got %h want %h", res, exp); end
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL flush_after_latency: got %0d want %0d", lat, elat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, exp;
    int          lat, elat;
    bit          to;
    issue(5'd18, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL rstmid_pre_state: got %0d want 1", state); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 32'd0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: ready=%b valid=%b result=%h state=%0d want 1 0 0 0",
               req_ready, resp_valid, result, state);
    end
    clear_model_cache();
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd17, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b1);
    wait_resp(res, lat, to);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    n_checks++;
    if (to || res !== exp) begin n_fail++; $display("FAIL rstmid_after_result: got %h want %h", res, exp); end
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d want %0d", lat, elat); end
  endtask

  task automatic test_back_to_back_cache();
    logic [31:0] res, exp;
    int          lat, elat;
    bit          to;
    issue(5'd17, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 1'b1);
    wait_resp(res, lat, to);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    n_checks++;
    if (to || res !== exp) begin n_fail++; $display("FAIL cache_div_result: got %h want %h", res, exp); end
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL cache_div_latency: got %0d want %0d", lat, elat); end
    issue(5'd19, 32'd1000, 32'hFFFF_FFFD, 32'd1, 1'b1);
    wait_resp(res, lat, to);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    n_checks++;
    if (to || res !== exp) begin n_fail++; $display("FAIL cache_rem_result: got %h want %h", res, exp); end
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL cache_rem_latency: got %0d want %0d", lat, elat); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_table();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back_cache();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
